keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment driver. Scans a 4x4 matrix keypad (Pmod KYPD style) by driving one active-low column at a time and sampling the active-low rows.
- Debounces across whole scan sweeps. Emits one pulse per debounced key press.
- Shifts entered hex digits into a 16-bit value that feeds the display's decimal_num input directly.

---
 rtl/keypad_scanner.sv | 216 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces over whole sweeps, pulses key_valid once per accepted press and
// shifts each accepted hex digit into entry_value (newest digit in [3:0]).
//
// Optional build macro KEYPAD_CLEAR_KEY_EN: when defined, accepting key F
// clears entry_value instead of shifting F in.
module keypad_scanner #(
    parameter int SCAN_TICKS      = 25000, // clk cycles per column, >= 4
    parameter int DEBOUNCE_SWEEPS = 4      // identical sweeps to accept, >= 1
) (
    input  logic        clk,
    input  logic        btnC,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] entry_value
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SWEEPS - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_CANDIDATE = 2'd1;
    localparam logic [1:0] ST_PRESSED   = 2'd2;
    localparam logic [1:0] ST_RELEASE   = 2'd3;

    logic [3:0]    row_meta, row_sync;
    logic [TW-1:0] timer;
    logic [1:0]    col_sel;
    logic          tick, sweep_end;
    logic          sweep_hit;
    logic [3:0]    sweep_code;
    logic          col_hit;
    logic [1:0]    row_idx;
    logic [3:0]    col_code;
    logic          res_hit;
    logic [3:0]    res_code;
    logic [1:0]    state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic [3:0]    cand, next_cand;
    logic          do_accept, do_release;

    // Hex code printed on the key at column c, row r.
    function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
        case ({c, r})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h4;
            4'h2: key_map = 4'h7;  4'h3: key_map = 4'h0;
            4'h4: key_map = 4'h2;  4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h8;  4'h7: key_map = 4'hF;
            4'h8: key_map = 4'h3;  4'h9: key_map = 4'h6;
            4'hA: key_map = 4'h9;  4'hB: key_map = 4'hE;
            4'hC: key_map = 4'hA;  4'hD: key_map = 4'hB;
            4'hE: key_map = 4'hC;  4'hF: key_map = 4'hD;
            default: key_map = 4'h0;
        endcase
    endfunction

    assign col       = ~(4'b0001 << col_sel);
    assign tick      = (timer == TIMER_LAST);
    assign sweep_end = tick && (col_sel == 2'd3);
    assign col_hit   = (row_sync != 4'hF);
    assign col_code  = key_map(col_sel, row_idx);
    // An earlier column in the sweep always beats the column sampled last.
    assign res_hit   = sweep_hit || col_hit;
    assign res_code  = sweep_hit ? sweep_code : col_code;

    // Two-flop synchronizer for the asynchronous row inputs; idle rows read high.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (btnC) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Lowest pressed row index within the current column.
    always_comb begin
        // NOTE: default first so no path leaves row_idx unassigned (no latch).
        row_idx = 2'd3;
        if      (!row_sync[0]) row_idx = 2'd0;
        else if (!row_sync[1]) row_idx = 2'd1;
        else if (!row_sync[2]) row_idx = 2'd2;
    end

    // Column dwell timer and column select.
    always_ff @(posedge clk) begin
        if (btnC) begin
            timer   <= '0;
            col_sel <= 2'd0;
        end else if (tick) begin
            timer   <= '0;
            col_sel <= col_sel + 2'd1;
        end else begin
            timer <= timer + TW'(1);
        end
    end

    // Remembers the first hit of the sweep in progress (columns 0..2).
    always_ff @(posedge clk) begin
        if (btnC) begin
            sweep_hit  <= 1'b0;
            sweep_code <= 4'h0;
        end else if (sweep_end) begin
            sweep_hit  <= 1'b0;
            sweep_code <= 4'h0;
        end else if (tick && !sweep_hit && col_hit) begin
            sweep_hit  <= 1'b1;
            sweep_code <= col_code;
        end
    end

    // Debounce decision, taken only on the sweep-end sample.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_cand  = cand;
        do_accept  = 1'b0;
        do_release = 1'b0;
        if (sweep_end) begin
            case (state)
                ST_IDLE: begin
                    if (res_hit) begin
                        next_cand = res_code;
                        next_cnt  = CNT_ONE;
                        if (DEBOUNCE_SWEEPS == 1) begin
                            do_accept  = 1'b1;
                            next_state = ST_PRESSED;
                        end else begin
                            next_state = ST_CANDIDATE;
                        end
                    end
                end
                ST_CANDIDATE: begin
                    if (!res_hit) begin
                        next_state = ST_IDLE;
                    end else if (res_code != cand) begin
                        next_cand = res_code;
                        next_cnt  = CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        do_accept  = 1'b1;
                        next_state = ST_PRESSED;
                    end else begin
                        next_cnt = cnt + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!res_hit) begin
                        if (DEBOUNCE_SWEEPS == 1) begin
                            do_release = 1'b1;
                            next_state = ST_IDLE;
                        end else begin
                            next_cnt   = CNT_ONE;
                            next_state = ST_RELEASE;
                        end
                    end
                end
                default: begin // ST_RELEASE
                    if (res_hit) begin
                        next_state = ST_PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        do_release = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        next_cnt = cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (btnC) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= 4'h0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            cand  <= next_cand;
        end
    end

    // Registered outputs: one-cycle pulse, held flag and entered value.
    always_ff @(posedge clk) begin
        if (btnC) begin
            key_valid   <= 1'b0;
            key_code    <= 4'h0;
            key_held    <= 1'b0;
            entry_value <= 16'h0000;
        end else begin
            key_valid <= do_accept;
            if (do_accept) begin
                key_code <= next_cand;
                key_held <= 1'b1;
`ifdef KEYPAD_CLEAR_KEY_EN
                if (next_cand == 4'hF) entry_value <= 16'h0000;
                else                   entry_value <= {entry_value[11:0], next_cand};
`else
                entry_value <= {entry_value[11:0], next_cand};
`endif
            end else if (do_release) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model plus scoreboard for keypad_scanner
// with SCAN_TICKS = 8 and DEBOUNCE_SWEEPS = 3 (32-cycle sweep).
module tb_keypad_scanner;

    localparam int SWEEP = 32;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] entry;
    } exp_t;

    logic        clk = 1'b0;
    logic        btnC;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] entry_value;

    logic [15:0] pressed;   // bit c*4+r set = key at column c, row r is down
    logic [15:0] exp_entry;
    logic [3:0]  exp_code;
    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    keypad_scanner #(.SCAN_TICKS(8), .DEBOUNCE_SWEEPS(3)) dut (
        .clk(clk), .btnC(btnC), .row(row), .col(col), .key_valid(key_valid),
        .key_code(key_code), .key_held(key_held), .entry_value(entry_value)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a pressed key joins it to the low column.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (col[c] == 1'b0 && pressed[c*4+r]) row[r] = 1'b0;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model of an accepted press: queue the pulse the DUT owes us.
    task automatic expect_press(input logic [3:0] code);
        exp_t e;
        exp_code = code;
`ifdef KEYPAD_CLEAR_KEY_EN
        exp_entry = (code == 4'hF) ? 16'h0000 : {exp_entry[11:0], code};
`else
        exp_entry = {exp_entry[11:0], code};
`endif
        e.code  = code;
        e.entry = exp_entry;
        sb.push_back(e);
    endtask

    task automatic hold_key(input int k, input int on_sweeps, input int off_sweeps);
        pressed[k] = 1'b1;
        cycles(on_sweeps * SWEEP);
        pressed[k] = 1'b0;
        cycles(off_sweeps * SWEEP);
    endtask

    // Wait until column 0 has just been entered, i.e. a new sweep begins.
    task automatic align();
        logic [3:0] prev;
        bit found;
        prev  = col;
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(posedge clk);
            #1;
            if (col == 4'b1110 && prev != 4'b1110) found = 1;
            prev = col;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL align: col=%b never re-entered column 0 in 80 cycles", col);
        end
    endtask

    task automatic check_drained(input string name);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_pulses: %0d expected key_valid pulses missing, want 0", name, sb.size());
        end
        sb.delete();
    endtask

    // Pops the scoreboard on every key_valid pulse.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (btnC === 1'b0 && key_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL pulse_unexpected: key_valid=1 code=%h entry=%h, want no pulse", key_code, entry_value);
                end else begin
                    e = sb.pop_front();
                    if (key_code !== e.code || entry_value !== e.entry || key_held !== 1'b1) begin
                        miscompares++;
                        $display("FAIL pulse: code=%h entry=%h held=%b, want code=%h entry=%h held=1",
                                 key_code, entry_value, key_held, e.code, e.entry);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] want;
        btnC = 1'b0;
        cycles(13);
        btnC = 1'b1;
        cycles(2);
        vectors++;
        if (col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 ||
            key_code !== 4'h0 || entry_value !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_state: col=%b valid=%b held=%b code=%h entry=%h, want 1110 0 0 0 0000",
                     col, key_valid, key_held, key_code, entry_value);
        end
        btnC = 1'b0;
        for (int k = 0; k < 4; k++) begin
            want = ~(4'b0001 << k);
            cycles(7);
            vectors++;
            if (col !== want) begin
                miscompares++;
                $display("FAIL reset_dwell%0d: col=%b want %b", k, col, want);
            end
            want = ~(4'b0001 << ((k + 1) % 4));
            cycles(1);
            vectors++;
            if (col !== want) begin
                miscompares++;
                $display("FAIL reset_step%0d: col=%b want %b", k, col, want);
            end
        end
    endtask

    task automatic test_single_press();
        align();
        expect_press(4'h5);
        pressed[5] = 1'b1;
        cycles(2 * SWEEP);
        vectors++;
        if (key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: key_held=%b after 2 sweeps, want 0", key_held);
        end
        cycles(SWEEP);
        vectors++;
        if (key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL single_accept: key_held=%b after 3 sweeps, want 1", key_held);
        end
        cycles(3 * SWEEP);
        vectors++;
        if (key_held !== 1'b1 || key_code !== 4'h5 || entry_value !== 16'h0005) begin
            miscompares++;
            $display("FAIL single_hold: held=%b code=%h entry=%h, want 1 5 0005", key_held, key_code, entry_value);
        end
        pressed[5] = 1'b0;
        cycles(2 * SWEEP);
        vectors++;
        if (key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL single_release_early: key_held=%b after 2 empty sweeps, want 1", key_held);
        end
        cycles(SWEEP);
        vectors++;
        if (key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: key_held=%b after 3 empty sweeps, want 0", key_held);
        end
        check_drained("single");
    endtask

    task automatic enter_1234();
        int         keys[4];
        logic [3:0] codes[4];
        keys  = '{0, 4, 8, 1};
        codes = '{4'h1, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 4; i++) begin
            expect_press(codes[i]);
            hold_key(keys[i], 4, 3);
        end
        vectors++;
        if (entry_value !== 16'h1234 || key_code !== 4'h4) begin
            miscompares++;
            $display("FAIL entry_1234: entry=%h code=%h, want 1234 4", entry_value, key_code);
        end
    endtask

    task automatic test_sequence();
        align();
        enter_1234();
        expect_press(4'hA);
        hold_key(12, 4, 3);
        vectors++;
        if (entry_value !== 16'h234A || key_code !== 4'hA) begin
            miscompares++;
            $display("FAIL seq_wrap: entry=%h code=%h, want 234a a", entry_value, key_code);
        end
        check_drained("sequence");
    endtask

    task automatic test_bounce();
        align();
        pressed[2] = 1'b1; cycles(2 * SWEEP);
        pressed[2] = 1'b0; cycles(SWEEP);
        pressed[2] = 1'b1; cycles(2 * SWEEP);
        pressed[2] = 1'b0; cycles(3 * SWEEP);
        vectors++;
        if (entry_value !== exp_entry || key_code !== exp_code || key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce: entry=%h code=%h held=%b, want %h %h 0",
                     entry_value, key_code, key_held, exp_entry, exp_code);
        end
        check_drained("bounce");
    endtask

    task automatic test_multi_key();
        align();
        expect_press(4'h1);
        pressed[0]  = 1'b1;
        pressed[12] = 1'b1;
        cycles(4 * SWEEP);
        vectors++;
        if (key_code !== 4'h1 || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL multi_priority: code=%h held=%b, want 1 1", key_code, key_held);
        end
        pressed[10] = 1'b1;
        cycles(3 * SWEEP);
        vectors++;
        if (key_code !== 4'h1 || entry_value !== exp_entry || key_held !== 1'b1) begin
            miscompares++;
            $display("FAIL multi_ignore: code=%h entry=%h held=%b, want 1 %h 1",
                     key_code, entry_value, key_held, exp_entry);
        end
        pressed = '0;
        cycles(3 * SWEEP);
        vectors++;
        if (key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_release: key_held=%b want 0", key_held);
        end
        check_drained("multi");
    endtask

    task automatic test_reset_pressed();
        align();
        expect_press(4'h8);
        pressed[6] = 1'b1;
        cycles(4 * SWEEP);
        check_drained("pre_reset");
        cycles(10);
        btnC = 1'b1;
        cycles(1);
        vectors++;
        if (col !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 ||
            key_code !== 4'h0 || entry_value !== 16'h0000) begin
            miscompares++;
            $display("FAIL midpress_reset: col=%b valid=%b held=%b code=%h entry=%h, want 1110 0 0 0 0000",
                     col, key_valid, key_held, key_code, entry_value);
        end
        exp_entry = 16'h0000;
        exp_code  = 4'h0;
        expect_press(4'h8);
        btnC = 1'b0;
        cycles(3 * SWEEP - 1);
        vectors++;
        if (key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL reaccept_early: key_held=%b one cycle before third sweep end, want 0", key_held);
        end
        cycles(1);
        vectors++;
        if (key_held !== 1'b1 || key_code !== 4'h8 || entry_value !== 16'h0008) begin
            miscompares++;
            $display("FAIL reaccept: held=%b code=%h entry=%h, want 1 8 0008", key_held, key_code, entry_value);
        end
        pressed = '0;
        cycles(3 * SWEEP);
        check_drained("reaccept");
    endtask

    task automatic test_clear_key();
        logic [15:0] want;
        align();
        enter_1234();
        expect_press(4'hF);
        want = exp_entry;
        hold_key(7, 4, 3);
        vectors++;
        if (entry_value !== want || key_code !== 4'hF) begin
            miscompares++;
            $display("FAIL clear_key: entry=%h code=%h, want %h f", entry_value, key_code, want);
        end
        check_drained("clear_key");
    endtask

    initial begin
        btnC      = 1'b1;
        pressed   = '0;
        exp_entry = 16'h0000;
        exp_code  = 4'h0;
        cycles(3);
        fork
            monitor();
        join_none
        test_reset();
        test_single_press();
        test_sequence();
        test_bounce();
        test_multi_key();
        test_reset_pressed();
        test_clear_key();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
